// File: rtl/coax_tx_arbiter_if.sv
// rtl/coax_tx_arbiter_if.sv - requester, transmitter and status signals of the coax tx arbiter
interface coax_tx_arbiter_if #(
    parameter int DATA_WIDTH = 10
);
    logic                  req0_valid;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    logic                  tx_start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_active;
    logic                  grant_id;
    logic                  busy;
    logic                  done;
    logic                  timeout;

    // arbiter side
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_active,
        output req0_ready, req1_ready, tx_start, tx_data, grant_id, busy, done, timeout
    );

    // requester / transmitter side
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_active,
        input  req0_ready, req1_ready, tx_start, tx_data, grant_id, busy, done, timeout
    );
endinterface

// File: rtl/coax_tx_arbiter.sv
// rtl/coax_tx_arbiter.sv - round-robin sharing of one coax transmitter between two word requesters
module coax_tx_arbiter #(
    parameter int DATA_WIDTH    = 10,
    parameter int GAP_CLOCKS    = 64,
    parameter int START_TIMEOUT = 32
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_enable,
    coax_tx_arbiter_if.slave    bus
);
    localparam int CNT_MAX = (GAP_CLOCKS > START_TIMEOUT) ? GAP_CLOCKS : START_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CLOCKS > 0) ? GAP_CLOCKS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACTIVE,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_grant_id;
    logic                  r_last_grant;
    logic                  r_done;
    logic                  r_timeout;

    logic                  w_sel;
    logic                  w_ready0;
    logic                  w_ready1;
    logic                  w_accept;
    logic                  w_after_tx;

    // Fairness only matters on a tie; a lone requester is always the pick.
    assign w_sel      = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    assign w_ready0   = (r_state == S_IDLE) && i_enable && !w_sel && bus.req0_valid;
    assign w_ready1   = (r_state == S_IDLE) && i_enable &&  w_sel && bus.req1_valid;
    assign w_accept   = w_ready0 || w_ready1;
    // With no turnaround gap the line is immediately free again.
    assign w_after_tx = (GAP_CLOCKS == 0) ? 1'b1 : 1'b0;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_START;
            end
            S_START: begin
                w_state_nxt = S_WAIT_ACTIVE;
            end
            S_WAIT_ACTIVE: begin
                // A late rise on the limit cycle still counts as a start.
                if (bus.tx_active)        w_state_nxt = S_WAIT_DONE;
                else if (r_cnt == TO_LAST) w_state_nxt = w_after_tx ? S_IDLE : S_GAP;
            end
            S_WAIT_DONE: begin
                if (!bus.tx_active) w_state_nxt = w_after_tx ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Word latch, grant history, shared counter and status pulses
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt        <= '0;
            r_tx_data    <= '0;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b1;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tx_data    <= w_sel ? bus.req1_data : bus.req0_data;
                        r_grant_id   <= w_sel;
                        r_last_grant <= w_sel;
                    end
                end
                S_START: begin
                    r_cnt <= '0;
                end
                S_WAIT_ACTIVE: begin
                    if (!bus.tx_active) begin
                        if (r_cnt == TO_LAST) begin
                            r_timeout <= 1'b1;
                            r_cnt     <= '0;
                        end else if (r_cnt != '1) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.tx_active) begin
                        r_done <= 1'b1;
                        r_cnt  <= '0;
                    end
                end
                S_GAP: begin
                    if (r_cnt != GAP_LAST && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Output decode
    always_comb begin
        bus.req0_ready = w_ready0;
        bus.req1_ready = w_ready1;
        bus.tx_start   = (r_state == S_START);
        bus.tx_data    = r_tx_data;
        bus.grant_id   = r_grant_id;
        bus.busy       = (r_state != S_IDLE);
        bus.done       = r_done;
        bus.timeout    = r_timeout;
    end
endmodule

// File: tb/tb_coax_tx_arbiter.sv
// tb/tb_coax_tx_arbiter.sv - scoreboard bench for coax_tx_arbiter
module tb_coax_tx_arbiter;
    localparam int G  = 64;
    localparam int ST = 32;
    localparam int K_READY = 0, K_START = 1, K_DONE = 2, K_TMO = 3;

    typedef struct {
        int         kind;
        int         cyc;
        int         gid;
        logic [9:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic en = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   idle_at = 0;
    int   act_on = 0;
    int   act_off = 0;
    ev_t  q[$];
    int   xq_dly[$];
    int   xq_len[$];

    coax_tx_arbiter_if #(.DATA_WIDTH(10)) bus_a();
    coax_tx_arbiter_if #(.DATA_WIDTH(10)) bus_z();

    coax_tx_arbiter #(.DATA_WIDTH(10), .GAP_CLOCKS(G), .START_TIMEOUT(ST)) dut_a (
        .i_clk(clk), .i_reset_n(resetn), .i_enable(en), .bus(bus_a)
    );
    coax_tx_arbiter #(.DATA_WIDTH(10), .GAP_CLOCKS(0), .START_TIMEOUT(ST)) dut_z (
        .i_clk(clk), .i_reset_n(resetn), .i_enable(1'b1), .bus(bus_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_READY: return "ready";
            K_START: return "tx_start";
            K_DONE:  return "done";
            default: return "timeout";
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_xfer(input int who, input logic [9:0] d, input int a, input int dly, input int len);
        ev_t e;
        int  p;
        e.gid = who; e.data = d;
        e.kind = K_READY; e.cyc = a;     q.push_back(e);
        e.kind = K_START; e.cyc = a + 1; q.push_back(e);
        if (len > 0) begin p = a + 1 + dly + len + 1; e.kind = K_DONE; end
        else         begin p = a + 1 + ST + 1;        e.kind = K_TMO;  end
        e.cyc = p;
        q.push_back(e);
        xq_dly.push_back(dly);
        xq_len.push_back(len);
        idle_at = p + G;
    endtask

    task automatic observe(input int kind, input int gid, input logic [9:0] d);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s cyc=%0d gid=%0d data=%h required no event", kname(kind), cyc, gid, d);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.gid != gid || e.data != d) begin
                failures++;
                $display("FAIL event got %s cyc=%0d gid=%0d data=%h required %s cyc=%0d gid=%0d data=%h",
                         kname(kind), cyc, gid, d, kname(e.kind), e.cyc, e.gid, e.data);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},     int'(bus_a.busy), 0);
        chk({tag, "_tx_start"}, int'(bus_a.tx_start), 0);
        chk({tag, "_done"},     int'(bus_a.done), 0);
        chk({tag, "_timeout"},  int'(bus_a.timeout), 0);
        chk({tag, "_tx_data"},  int'(bus_a.tx_data), 0);
        chk({tag, "_grant_id"}, int'(bus_a.grant_id), 0);
    endtask

    // Monitor: every observable handshake or pulse is matched against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (bus_a.req0_ready || bus_a.req1_ready)
                    chk("one_ready", int'(bus_a.req0_ready && bus_a.req1_ready), 0);
                if (bus_a.req0_ready && bus_a.req0_valid) observe(K_READY, 0, bus_a.req0_data);
                if (bus_a.req1_ready && bus_a.req1_valid) observe(K_READY, 1, bus_a.req1_data);
                if (bus_a.tx_start) observe(K_START, int'(bus_a.grant_id), bus_a.tx_data);
                if (bus_a.done)     observe(K_DONE,  int'(bus_a.grant_id), bus_a.tx_data);
                if (bus_a.timeout)  observe(K_TMO,   int'(bus_a.grant_id), bus_a.tx_data);
            end
        end
    end

    // Transmitter model: each start consumes the next programmed delay/length
    initial begin
        forever begin
            @(negedge clk);
            if (bus_a.tx_start && xq_dly.size() > 0) begin
                act_on  = cyc + xq_dly.pop_front();
                act_off = act_on + xq_len.pop_front();
            end
        end
    end

    always @(posedge clk) begin
        #1;
        bus_a.tx_active = (cyc >= act_on) && (cyc < act_off);
    end

    initial begin
        repeat (20000) @(posedge clk);
        failures++;
        $display("FAIL watchdog cyc=%0d required finish before 20000 cycles", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int a;
        int a2;
        int d_cyc;
        logic seen;
        bus_a.req0_valid = 0; bus_a.req1_valid = 0; bus_a.req0_data = 0; bus_a.req1_data = 0;
        bus_z.req0_valid = 0; bus_z.req1_valid = 0; bus_z.req0_data = 0; bus_z.req1_data = 0;
        bus_z.tx_active = 0;
        repeat (3) tick();
        check_reset_outputs("reset");
        resetn = 1;
        tick();

        // Contention: alternate grants starting with requester 0
        bus_a.req0_valid = 1; bus_a.req0_data = 10'h001;
        bus_a.req1_valid = 1; bus_a.req1_data = 10'h002;
        for (int k = 0; k < 4; k++) begin
            a = (k == 0) ? cyc : idle_at;
            expect_xfer(k % 2, (k % 2) ? 10'h002 : 10'h001, a, 3, 5);
            while (cyc < a + 1) tick();
        end
        bus_a.req0_valid = 0; bus_a.req1_valid = 0;
        while (cyc < idle_at) tick();

        // Single word, then a request raised the cycle after done waits out the gap
        a = cyc;
        bus_a.req0_valid = 1; bus_a.req0_data = 10'h105;
        expect_xfer(0, 10'h105, a, 2, 38);
        d_cyc = idle_at - G;
        tick();
        bus_a.req0_valid = 0;
        while (cyc < d_cyc + 1) tick();
        bus_a.req1_valid = 1; bus_a.req1_data = 10'h2AA;
        a2 = idle_at;
        expect_xfer(1, 10'h2AA, a2, 1, 1);
        while (cyc < a2 - 1) tick();
        chk("busy_last_gap_cycle", int'(bus_a.busy), 1);
        tick();
        chk("busy_first_idle_cycle", int'(bus_a.busy), 0);
        tick();
        bus_a.req1_valid = 0;
        while (cyc < idle_at) tick();

        // Start timeout, with the other requester granted once the gap ends
        a = cyc;
        bus_a.req0_valid = 1; bus_a.req0_data = 10'h0F0;
        expect_xfer(0, 10'h0F0, a, 0, 0);
        a2 = idle_at;
        expect_xfer(1, 10'h30F, a2, 1, 2);
        tick();
        bus_a.req0_valid = 0;
        bus_a.req1_valid = 1; bus_a.req1_data = 10'h30F;
        while (cyc < a2 + 1) tick();
        bus_a.req1_valid = 0;
        while (cyc < idle_at) tick();

        // Enable low blocks grants; dropping it mid-transmission still lets it finish
        en = 0;
        bus_a.req0_valid = 1; bus_a.req0_data = 10'h011;
        bus_a.req1_valid = 1; bus_a.req1_data = 10'h022;
        seen = 0;
        repeat (20) begin
            tick();
            seen |= bus_a.req0_ready | bus_a.req1_ready | bus_a.tx_start;
        end
        chk("enable_low_no_grant", int'(seen), 0);
        en = 1;
        a = cyc;
        expect_xfer(0, 10'h011, a, 2, 30);
        tick();
        bus_a.req0_valid = 0;
        while (cyc < a + 10) tick();
        en = 0;
        seen = 0;
        a2 = idle_at + 20;
        while (cyc < a2) begin
            tick();
            seen |= bus_a.req1_ready;
        end
        chk("enable_drop_no_new_grant", int'(seen), 0);
        chk("enable_drop_idle", int'(bus_a.busy), 0);
        en = 1;
        a = cyc;
        expect_xfer(1, 10'h022, a, 2, 5);
        tick();
        bus_a.req1_valid = 0;
        while (cyc < idle_at) tick();

        // Reset while waiting for the transmitter to finish
        a = cyc;
        bus_a.req0_valid = 1; bus_a.req0_data = 10'h3C3;
        expect_xfer(0, 10'h3C3, a, 2, 100);
        q.delete(q.size() - 1);
        tick();
        bus_a.req0_valid = 0;
        while (cyc < a + 10) tick();
        resetn = 0;
        act_off = 0;
        tick();
        resetn = 1;
        check_reset_outputs("midreset");
        a = cyc;
        bus_a.req0_valid = 1; bus_a.req0_data = 10'h0AB;
        bus_a.req1_valid = 1; bus_a.req1_data = 10'h0CD;
        expect_xfer(0, 10'h0AB, a, 1, 2);
        tick();
        bus_a.req0_valid = 0; bus_a.req1_valid = 0;
        while (cyc < idle_at) tick();

        // Zero-gap build: ready again on the very cycle done pulses
        bus_z.req0_valid = 1; bus_z.req0_data = 10'h155;
        #2;
        chk("z_ready0", int'(bus_z.req0_ready), 1);
        tick();
        bus_z.req0_valid = 0;
        #2;
        chk("z_tx_start", int'(bus_z.tx_start), 1);
        chk("z_tx_data", int'(bus_z.tx_data), 10'h155);
        tick();
        bus_z.tx_active = 1;
        tick();
        tick();
        bus_z.tx_active = 0;
        tick();
        bus_z.req1_valid = 1; bus_z.req1_data = 10'h0AA;
        #2;
        chk("z_done", int'(bus_z.done), 1);
        chk("z_busy", int'(bus_z.busy), 0);
        chk("z_ready1", int'(bus_z.req1_ready), 1);
        tick();
        bus_z.req1_valid = 0;
        #2;
        chk("z_tx_start2", int'(bus_z.tx_start), 1);
        chk("z_tx_data2", int'(bus_z.tx_data), 10'h0AA);
        repeat (4) tick();

        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
